// File: rtl/exec_alu_md.sv
// Execute unit: registered single-cycle ALU plus an iterative unsigned
// multiply/divide engine (one bit per cycle), valid/ready on both sides.
module exec_alu_md #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_opr,
  input  logic [SHW-1:0]  in_shift,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_wra,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_wra,
  output logic            busy
);

  localparam int unsigned CNTW = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NAND = 5'd11;
  localparam logic [4:0] OP_SLL  = 5'd16;
  localparam logic [4:0] OP_SRL  = 5'd17;
  localparam logic [4:0] OP_SRA  = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;        // mul: high half; div: partial remainder
  logic [XLEN-1:0]   mq_q, mq_d;          // mul: low half/multiplier; div: dividend/quotient
  logic [XLEN-1:0]   b_q, b_d;
  logic [1:0]        md_op_q, md_op_d;    // [1]=divide, [0]=high half / remainder
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [4:0]        out_wra_q, out_wra_d;

  logic              accept;
  logic              is_md;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc, mul_mq;
  logic [XLEN:0]     div_shifted;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [XLEN-1:0]   md_final;

  assign is_md  = (in_opr[4:2] == 3'b110);
  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_md ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (cnt_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept)         state_d = is_md ? S_RUN : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: in_ready = !rst;
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = !rst && out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = '1;
    case (in_opr)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_NAND: alu_res = ~(in_a & in_b);
      OP_SLL:  alu_res = in_a << in_shift;
      OP_SRL:  alu_res = in_a >> in_shift;
      OP_SRA:  alu_res = XLEN'($signed(in_a) >>> in_shift);
      default: alu_res = '1;
    endcase
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : (XLEN + 1)'(0));
    mul_acc     = mul_sum[XLEN:1];
    mul_mq      = {mul_sum[0], mq_q[XLEN-1:1]};
    div_shifted = {acc_q, mq_q[XLEN-1]};
    div_diff    = {1'b0, div_shifted} - {2'b00, b_q};
    if (!div_diff[XLEN+1]) begin
      div_rem = div_diff[XLEN-1:0];
      div_quo = {mq_q[XLEN-2:0], 1'b1};
    end else begin
      div_rem = div_shifted[XLEN-1:0];
      div_quo = {mq_q[XLEN-2:0], 1'b0};
    end
    case (md_op_q)
      2'b00:   md_final = mul_mq;
      2'b01:   md_final = mul_acc;
      2'b10:   md_final = div_quo;
      default: md_final = div_rem;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mq_d         = mq_q;
    b_d          = b_q;
    md_op_d      = md_op_q;
    out_result_d = out_result_q;
    out_wra_d    = out_wra_q;
    if (state_q == S_RUN) begin
      acc_d = md_op_q[1] ? div_rem : mul_acc;
      mq_d  = md_op_q[1] ? div_quo : mul_mq;
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) out_result_d = md_final;
    end else if (accept) begin
      out_wra_d = in_wra;
      if (is_md) begin
        acc_d   = '0;
        mq_d    = in_a;
        b_d     = in_b;
        md_op_d = in_opr[1:0];
        cnt_d   = CNTW'(XLEN);
      end else begin
        out_result_d = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      mq_q         <= '0;
      b_q          <= '0;
      md_op_q      <= '0;
      out_result_q <= '0;
      out_wra_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mq_q         <= mq_d;
      b_q          <= b_d;
      md_op_q      <= md_op_d;
      out_result_q <= out_result_d;
      out_wra_q    <= out_wra_d;
    end
  end

  assign out_result = out_result_q;
  assign out_wra    = out_wra_q;

endmodule

// File: tb/tb_exec_alu_md.sv
// Directed bench for exec_alu_md: ALU vector table, multiply/divide
// sequences, backpressure and reset-during-divide.
module tb_exec_alu_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opr;
  logic [4:0]  in_shift;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_wra;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_wra;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  exec_alu_md #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opr(in_opr), .in_shift(in_shift), .in_a(in_a), .in_b(in_b), .in_wra(in_wra),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wra(out_wra), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opr;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wra;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] opr, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wra);
    in_valid = 1'b1;
    in_opr   = opr;
    in_shift = sh;
    in_a     = a;
    in_b     = b;
    in_wra   = wra;
  endtask

  task automatic run_md(input string nm, input logic [4:0] opr, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wra, input logic [31:0] exp);
    int  cyc;
    int  busyc;
    bit  got;
    @(negedge clk);
    drive(opr, 5'd0, a, b, wra);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    cyc   = 0;
    busyc = 0;
    got   = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) got = 1;
      else if (busy) busyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd33);
    chk({nm, " busy cycles"}, 32'(busyc), 32'd32);
    chk({nm, " result"}, out_result, exp);
    chk({nm, " wra"}, 32'(out_wra), 32'(wra));
  endtask

  initial begin
    vecs[0]  = '{5'd0,  5'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  32'h0000_0000};
    vecs[1]  = '{5'd1,  5'd0,  32'h0000_0003, 32'h0000_0005, 5'd2,  32'hFFFF_FFFE};
    vecs[2]  = '{5'd18, 5'd4,  32'h8000_0000, 32'h0000_0000, 5'd3,  32'hF800_0000};
    vecs[3]  = '{5'd17, 5'd4,  32'h8000_0000, 32'h0000_0000, 5'd4,  32'h0800_0000};
    vecs[4]  = '{5'd11, 5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5,  32'h0FFF_0FFF};
    vecs[5]  = '{5'd7,  5'd0,  32'h1234_5678, 32'h9ABC_DEF0, 5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{5'd8,  5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0};
    vecs[7]  = '{5'd9,  5'd0,  32'h1234_0000, 32'h0000_5678, 5'd31, 32'h1234_5678};
    vecs[8]  = '{5'd10, 5'd0,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7,  32'hF0F0_0F0F};
    vecs[9]  = '{5'd16, 5'd31, 32'h0000_0001, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000};
    vecs[10] = '{5'd18, 5'd30, 32'h4000_0000, 32'h0000_0000, 5'd9,  32'h0000_0001};
    vecs[11] = '{5'd0,  5'd3,  32'h0000_1000, 32'h0000_0234, 5'd10, 32'h0000_1234};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opr    = '0;
    in_shift  = '0;
    in_a      = '0;
    in_b      = '0;
    in_wra    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_wra", 32'(out_wra), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].opr, vecs[i].sh, vecs[i].a, vecs[i].b, vecs[i].wra);
      chk($sformatf("alu%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("alu%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("alu%0d result", i), out_result, vecs[i].exp);
      chk($sformatf("alu%0d wra", i), 32'(out_wra), 32'(vecs[i].wra));
    end
    in_valid = 1'b0;

    run_md("mul 2^16*2^16",    5'd24, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'h0000_0000);
    run_md("mulhu 2^16*2^16",  5'd25, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h0000_0001);
    run_md("mul max*max",      5'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001);
    run_md("mulhu max*max",    5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE);
    run_md("divu 100/7",       5'd26, 32'd100,       32'd7,         5'd15, 32'd14);
    run_md("remu 100/7",       5'd27, 32'd100,       32'd7,         5'd16, 32'd2);
    run_md("divu 5/0",         5'd26, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF);
    run_md("remu 5/0",         5'd27, 32'd5,         32'd0,         5'd0,  32'd5);
    run_md("divu max/1",       5'd26, 32'hFFFF_FFFF, 32'd1,         5'd18, 32'hFFFF_FFFF);

    // Backpressure: result held, new op waits for out_ready
    @(negedge clk);
    out_ready = 1'b0;
    drive(5'd0, 5'd0, 32'd1, 32'd2, 5'd5);
    @(posedge clk);
    #1;
    drive(5'd10, 5'd0, 32'hAAAA_0000, 32'h0000_5555, 5'd20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d result", k), out_result, 32'd3);
      chk($sformatf("bp%0d wra", k), 32'(out_wra), 32'd5);
      chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp next out_valid", 32'(out_valid), 32'd1);
    chk("bp next result", out_result, 32'hAAAA_5555);
    chk("bp next wra", 32'(out_wra), 32'd20);

    // Reset in the 10th RUN cycle of a divide
    @(negedge clk);
    drive(5'd26, 5'd0, 32'd100, 32'd7, 5'd9);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst out_result", out_result, 32'd0);
    rst = 1'b0;
    drive(5'd0, 5'd0, 32'd2, 32'd2, 5'd3);
    #1;
    chk("after rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("after rst add valid", 32'(out_valid), 32'd1);
    chk("after rst add result", out_result, 32'd4);
    chk("after rst add wra", 32'(out_wra), 32'd3);
    @(posedge clk);
    #1;
    chk("after rst retire", 32'(out_valid), 32'd0);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("no stale divide output", 32'(out_valid), 32'd0);
        break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
